dma_tx_sequencer: RTL and testbench
===================================

DMA_TX_SEQUENCER -- requirements
Module: dma_tx_sequencer

Interface
REQ-001 Parameter MAX_BURST, default 16, maximum beats per AXI read burst (power of 2, 1..256).
REQ-002 Parameter TIMEOUT_CYC, default 1024, watchdog limit in cycles (used only with DMA_TX_TIMEOUT_EN).
REQ-003 Port clks  input  AXI_clks.to_rtl  one clock clks.clk; reset clks.rst, asynchronous, active-low.
REQ-004 Port start  input  1  enable: process descriptors while high.
REQ-005 Port stack_empty  input  1  link stack has no pending descriptor.
REQ-006 Port haddr  input  64  head descriptor: [31:0] byte address, [47:32] byte length, [63] end-of-frame.
REQ-007 Port pop  output  1  one-cycle pop strobe to link stack (drives its rd_en).
REQ-008 Ports m_araddr output 32, m_arlen output 8, m_arsize output 3, m_arvalid output 1, m_arready input 1: AXI read address channel.
REQ-009 Ports m_rdata input 64, m_rresp input 2, m_rlast input 1, m_rvalid input 1, m_rready output 1: AXI read data channel.
REQ-010 Ports tx_data output 64, tx_keep output 8, tx_last output 1, tx_valid output 1, tx_ready input 1: stream to TX FIFO.
REQ-011 Ports busy output 1 (state != IDLE), desc_done output 1 (pulse), err output 1 (sticky), timeout output 1 (pulse).

Function
REQ-012 FSM states IDLE, FETCH, ADDR, DATA, DONE shall be the only states.
REQ-013 IDLE->FETCH when start & !stack_empty; otherwise stay IDLE.
REQ-014 FETCH: pop=1 for exactly one cycle; latch haddr address, length, eof the same cycle; beats_left = ceil(len/8); ->ADDR.
REQ-015 Length 0 descriptor: set err, no AXI traffic, FETCH->DONE.
REQ-016 ADDR: m_arvalid=1, m_araddr=cur_addr, m_arlen=min(beats_left,MAX_BURST)-1, m_arsize=3'b011; araddr/arlen stable until m_arready; on handshake ->DATA.
REQ-017 DATA: tx_valid=m_rvalid, m_rready=tx_ready, tx_data=m_rdata (combinational, zero latency); beat counts on m_rvalid & tx_ready.
REQ-018 tx_keep=8'hFF except final descriptor beat: low (len mod 8) bits set, 8'hFF if len mod 8 == 0.
REQ-019 tx_last=1 only on final descriptor beat and only if eof=1.
REQ-020 Burst end (internal burst beat count reaches arlen+1): if beats_left==0 ->DONE, else cur_addr += 8*beats of that burst, ->ADDR.
REQ-021 Internal count is authoritative; m_rlast disagreeing with it, or m_rresp != 0 on any beat, sets err; transfer continues.
REQ-022 DONE: desc_done=1 one cycle; ->FETCH if start & !stack_empty, else ->IDLE.
REQ-023 start falling mid-descriptor shall not abort; current descriptor completes.
REQ-024 pop shall never assert when stack_empty=1.
REQ-025 Outside ADDR: m_arvalid=0; outside DATA: m_rready=0, tx_valid=0.

Reset
REQ-026 clks.rst low asynchronously forces IDLE; all outputs 0 except m_arsize=3'b011; err, counters, latched descriptor cleared.
REQ-027 Reset mid-burst abandons the transfer; no pop, desc_done or timeout issued on release.

Configuration
REQ-028 With DMA_TX_TIMEOUT_EN defined: cycle counter clears on any AR or R handshake and on entry to ADDR; at TIMEOUT_CYC in ADDR/DATA, timeout=1 one cycle, err set, FSM ->IDLE.
REQ-029 Without DMA_TX_TIMEOUT_EN: no counter; timeout tied 0; FSM waits indefinitely.

Structure
REQ-030 Shared package dma_pkg holds FSM state enum, descriptor struct typedef (addr/len/eof), beat-bytes constant 8.
REQ-031 No sub-module; burst-length and keep computation remain in-module.

Verification
REQ-032 Descriptor addr 0x1000, len 64, eof=1 -> one burst araddr 0x1000, arlen 7; 8 beats, tx_keep 8'hFF, tx_last on beat 8, one pop, one desc_done.
REQ-033 len 300, addr 0x2000, eof=1 -> bursts 0x2000/arlen 15, 0x2080/arlen 15, 0x2100/arlen 5; last beat tx_keep 8'h0F, tx_last=1.
REQ-034 Two descriptors queued, tx_ready toggled 50% -> no beat lost or duplicated, m_rready tracks tx_ready, FETCH follows DONE without IDLE.
REQ-035 m_rresp=2'b10 on beat 3 of 8 -> err=1 and stays 1, all 8 beats forwarded, desc_done issued.
REQ-036 len 0 descriptor -> err=1, no m_arvalid, desc_done after one pop.
REQ-037 DMA_TX_TIMEOUT_EN, TIMEOUT_CYC 32, m_arready held 0 -> timeout pulse at cycle 32 of ADDR, err=1, busy=0 next cycle.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types for the DMA TX sequencer: FSM states, descriptor layout, beat size.
package dma_pkg;
  localparam int BEAT_BYTES = 8;

  typedef enum logic [2:0] {IDLE, FETCH, ADDR, DATA, DONE} state_e;

  typedef struct packed {
    logic        eof;
    logic [15:0] len;
    logic [31:0] addr;
  } desc_t;

  // Beats needed to move len bytes; widened so len=16'hFFFF cannot wrap.
  function automatic logic [13:0] beats_of(input logic [15:0] len);
    logic [16:0] s;
    s = {1'b0, len} + 17'(BEAT_BYTES - 1);
    return s[16:3];
  endfunction
endpackage

// File: rtl/axi_clks.sv
// Clock/reset bundle; rst is asynchronous active-low.
interface AXI_clks;
  logic clk;
  logic rst;
  modport to_rtl (input clk, input rst);
endinterface

// File: rtl/dma_tx_sequencer.sv
// Pops descriptors, issues AXI read bursts and forwards read beats to the TX stream.
// Optional watchdog enabled by defining DMA_TX_TIMEOUT_EN.
module dma_tx_sequencer
  import dma_pkg::*;
#(
  parameter int MAX_BURST   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  AXI_clks.to_rtl      clks,
  input  logic         start,
  input  logic         stack_empty,
  input  logic [63:0]  haddr,
  output logic         pop,
  output logic [31:0]  m_araddr,
  output logic [7:0]   m_arlen,
  output logic [2:0]   m_arsize,
  output logic         m_arvalid,
  input  logic         m_arready,
  input  logic [63:0]  m_rdata,
  input  logic [1:0]   m_rresp,
  input  logic         m_rlast,
  input  logic         m_rvalid,
  output logic         m_rready,
  output logic [63:0]  tx_data,
  output logic [7:0]   tx_keep,
  output logic         tx_last,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         desc_done,
  output logic         err,
  output logic         timeout
);
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  len_lo_q, len_lo_d;
  logic        eof_q, eof_d;
  logic [13:0] beats_q, beats_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic        err_q, err_d;
  desc_t       hd;
  logic        in_data, beat, last_beat, burst_end;
  logic [7:0]  keep;
  logic        unused_haddr;

  assign hd           = '{eof: haddr[63], len: haddr[47:32], addr: haddr[31:0]};
  assign unused_haddr = ^haddr[62:48];

  function automatic logic [7:0] arlen_of(input logic [13:0] b);
    return (b > 14'(MAX_BURST)) ? 8'(MAX_BURST - 1) : 8'(b - 14'd1);
  endfunction

  assign in_data   = (state_q == DATA);
  assign beat      = in_data & m_rvalid & tx_ready;
  assign last_beat = (beats_q == 14'd1);
  assign burst_end = (bcnt_q == arlen_q);
  assign keep      = (last_beat && len_lo_q != 3'd0) ? ~(8'hFF << len_lo_q) : 8'hFF;

`ifdef DMA_TX_TIMEOUT_EN
  localparam int CYC_W = $clog2(TIMEOUT_CYC + 1);
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             timeout_q, timeout_d;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_lo_d = len_lo_q;
    eof_d    = eof_q;
    beats_d  = beats_q;
    arlen_d  = arlen_q;
    bcnt_d   = bcnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (start && !stack_empty) state_d = FETCH;
      FETCH: begin
        addr_d   = hd.addr;
        len_lo_d = hd.len[2:0];
        eof_d    = hd.eof;
        beats_d  = beats_of(hd.len);
        arlen_d  = arlen_of(beats_of(hd.len));
        if (hd.len == 16'd0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = ADDR;
        end
      end
      ADDR: if (m_arready) begin
        bcnt_d  = '0;
        state_d = DATA;
      end
      DATA: if (beat) begin
        beats_d = beats_q - 14'd1;
        bcnt_d  = bcnt_q + 8'd1;
        // Our own beat count decides burst end; a bad rlast/rresp only flags err.
        if (m_rresp != 2'b00 || m_rlast != burst_end) err_d = 1'b1;
        if (burst_end) begin
          if (last_beat) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + {20'd0, {1'b0, arlen_q} + 9'd1, 3'b000};
            arlen_d = arlen_of(beats_q - 14'd1);
            state_d = ADDR;
          end
        end
      end
      DONE: state_d = (start && !stack_empty) ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
`ifdef DMA_TX_TIMEOUT_EN
    timeout_d = 1'b0;
    cyc_d     = '0;
    if (state_q == ADDR || state_q == DATA) begin
      if ((m_arvalid && m_arready) || beat) begin
        cyc_d = '0;
      end else if (cyc_q == CYC_W'(TIMEOUT_CYC - 1)) begin
        timeout_d = 1'b1;
        err_d     = 1'b1;
        state_d   = IDLE;
      end else begin
        cyc_d = cyc_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clks.clk or negedge clks.rst) begin
    if (!clks.rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_lo_q  <= '0;
      eof_q     <= 1'b0;
      beats_q   <= '0;
      arlen_q   <= '0;
      bcnt_q    <= '0;
      err_q     <= 1'b0;
`ifdef DMA_TX_TIMEOUT_EN
      cyc_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_lo_q  <= len_lo_d;
      eof_q     <= eof_d;
      beats_q   <= beats_d;
      arlen_q   <= arlen_d;
      bcnt_q    <= bcnt_d;
      err_q     <= err_d;
`ifdef DMA_TX_TIMEOUT_EN
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign pop       = (state_q == FETCH);
  assign desc_done = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign m_arvalid = (state_q == ADDR);
  assign m_araddr  = m_arvalid ? addr_q : '0;
  assign m_arlen   = m_arvalid ? arlen_q : '0;
  assign m_arsize  = 3'b011;
  assign m_rready  = in_data & tx_ready;
  assign tx_valid  = in_data & m_rvalid;
  assign tx_data   = in_data ? m_rdata : '0;
  assign tx_keep   = in_data ? keep : '0;
  assign tx_last   = in_data & last_beat & eof_q;
endmodule

// File: tb/tb_dma_tx_sequencer.sv
// Randomized bench for dma_tx_sequencer against a burst/beat list derived from the descriptors.
module tb_dma_tx_sequencer;
  localparam int MB = 16;
  localparam int TO = 32;

  AXI_clks clks();
  logic        start, stack_empty, pop;
  logic [63:0] haddr, m_rdata, tx_data;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen, tx_keep;
  logic [2:0]  m_arsize;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic [1:0]  m_rresp;
  logic        tx_last, tx_valid, tx_ready, busy, desc_done, err, timeout;

  dma_tx_sequencer #(.MAX_BURST(MB), .TIMEOUT_CYC(TO)) dut (
    .clks(clks), .start(start), .stack_empty(stack_empty), .haddr(haddr), .pop(pop),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .tx_data(tx_data), .tx_keep(tx_keep),
    .tx_last(tx_last), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .desc_done(desc_done), .err(err), .timeout(timeout)
  );

  initial begin
    clks.clk = 1'b0;
    forever #5 clks.clk = ~clks.clk;
  end

  typedef struct { logic [31:0] a; int len; bit eof; } d_t;
  d_t          dq[$];
  logic [31:0] exp_ba[$];
  int          exp_bl[$];
  logic [7:0]  exp_keep[$];
  bit          exp_last[$];
  int          sl_q[$];
  int          checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected bursts and beats straight from the descriptor arithmetic.
  task automatic add_desc(input logic [31:0] a, input int len, input bit eof);
    int nb, rem, b;
    logic [31:0] ad;
    dq.push_back('{a: a, len: len, eof: eof});
    nb  = (len + 7) / 8;
    rem = nb;
    ad  = a;
    while (rem > 0) begin
      b = (rem > MB) ? MB : rem;
      exp_ba.push_back(ad);
      exp_bl.push_back(b - 1);
      ad  = ad + 32'(8 * b);
      rem = rem - b;
    end
    for (int k = 0; k < nb; k++) begin
      exp_keep.push_back((k == nb - 1 && len % 8 != 0) ? 8'((1 << (len % 8)) - 1) : 8'hFF);
      exp_last.push_back(k == nb - 1 && eof);
    end
  endtask

  task automatic do_reset(input bit check_vals);
    @(negedge clks.clk);
    clks.rst = 1'b0; start = 1'b0; stack_empty = 1'b1; haddr = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = '0; m_rdata = '0; tx_ready = 1'b0;
    #1;
    if (check_vals) begin
      chk("rst_busy", busy, 0);       chk("rst_pop", pop, 0);
      chk("rst_arvalid", m_arvalid, 0); chk("rst_arsize", m_arsize, 3'b011);
      chk("rst_araddr", m_araddr, 0); chk("rst_rready", m_rready, 0);
      chk("rst_txvalid", tx_valid, 0); chk("rst_txkeep", tx_keep, 0);
      chk("rst_err", err, 0);         chk("rst_done", desc_done, 0);
      chk("rst_timeout", timeout, 0);
    end
    repeat (2) @(negedge clks.clk);
    clks.rst = 1'b1;
    dq.delete(); exp_ba.delete(); exp_bl.delete(); exp_keep.delete(); exp_last.delete(); sl_q.delete();
  endtask

  task automatic run(input int rdy_pct, input int bad_beat, input bit flip_last,
                     input bit exp_err, input string tag);
    int n, pops, done, gaps, viol, bi, cyc;
    bit consumed;
    n = dq.size(); pops = 0; done = 0; gaps = 0; viol = 0; bi = 0; cyc = 0; consumed = 0;
    start = 1'b1;
    while (done < n && cyc < 5000) begin
      @(negedge clks.clk);
      cyc++;
      if (consumed) begin m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = '0; consumed = 0; end
      stack_empty = (dq.size() == 0);
      haddr = stack_empty ? {$urandom, $urandom} : {dq[0].eof, 15'd0, 16'(dq[0].len), dq[0].a};
      m_arready = 1'($urandom_range(0, 1));
      tx_ready  = ($urandom_range(0, 99) < rdy_pct);
      if (!m_rvalid && sl_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        m_rvalid = 1'b1;
        m_rdata  = {$urandom, $urandom};
        m_rresp  = (bi == bad_beat) ? 2'b10 : 2'b00;
        m_rlast  = (sl_q[0] == 1) ^ flip_last;
      end
      #1;
      if (pop) begin
        pops++;
        if (stack_empty) viol++;
        if (dq.size() > 0) dq.delete(0);
      end
      if (m_arvalid && m_arready) begin
        if (exp_ba.size() == 0) chk({tag, "_extra_burst"}, 1, 0);
        else begin
          chk({tag, "_araddr"}, m_araddr, exp_ba.pop_front());
          chk({tag, "_arlen"}, m_arlen, exp_bl.pop_front());
          chk({tag, "_arsize"}, m_arsize, 3'b011);
        end
        sl_q.push_back(int'(m_arlen) + 1);
      end
      if (m_rvalid && (m_rready !== tx_ready || tx_valid !== 1'b1)) viol++;
      if (!m_rvalid && tx_valid !== 1'b0) viol++;
      if (m_rvalid && tx_ready) begin
        consumed = 1;
        sl_q[0]--;
        if (sl_q[0] == 0) sl_q.delete(0);
        if (exp_keep.size() == 0) chk({tag, "_extra_beat"}, 1, 0);
        else begin
          chk({tag, "_data"}, tx_data, m_rdata);
          chk({tag, "_keep"}, tx_keep, exp_keep.pop_front());
          chk({tag, "_last"}, tx_last, exp_last.pop_front());
        end
        bi++;
      end
      if (desc_done) done++;
      if (pops > 0 && done < n && !busy) gaps++;
    end
    start = 1'b0;
    @(negedge clks.clk);
    m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = '0; stack_empty = 1'b1;
    #1;
    chk({tag, "_done_cnt"}, done, n);
    chk({tag, "_pop_cnt"}, pops, n);
    chk({tag, "_bursts_left"}, exp_ba.size(), 0);
    chk({tag, "_beats_left"}, exp_keep.size(), 0);
    chk({tag, "_handshake_viol"}, viol, 0);
    chk({tag, "_idle_gaps"}, gaps, 0);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_idle_after"}, busy, 0);
  endtask

  initial begin
    int k, cnt;
    clks.rst = 1'b0;
    do_reset(1);

    add_desc(32'h1000, 64, 1);   run(100, -1, 0, 0, "d64");
    do_reset(0);
    add_desc(32'h2000, 300, 1);  run(100, -1, 0, 0, "d300");
    do_reset(0);
    add_desc(32'h5000, 100, 0); add_desc(32'h6008, 72, 1); run(50, -1, 0, 0, "two");
    do_reset(0);
    add_desc(32'h7000, 64, 1);   run(100, 2, 0, 1, "rresp");
    do_reset(0);
    add_desc(32'h3000, 0, 1);    run(100, -1, 0, 1, "len0");
    do_reset(0);
    add_desc(32'h8000, 64, 1);   run(100, -1, 1, 1, "rlast");
    do_reset(0);
    for (int i = 0; i < 5; i++)
      add_desc($urandom & 32'hFFFF_FFF8, $urandom_range(1, 400), 1'($urandom_range(0, 1)));
    run($urandom_range(30, 100), -1, 0, 0, "rand");

    // Reset in the middle of a burst must abandon it cleanly.
    do_reset(0);
    haddr = {1'b1, 15'd0, 16'd128, 32'h9000}; stack_empty = 1'b0; start = 1'b1;
    m_arready = 1'b1; tx_ready = 1'b1;
    k = 0;
    @(negedge clks.clk); #1;
    while (!m_arvalid && k < 20) begin @(negedge clks.clk); #1; k++; end
    chk("mr_arvalid", m_arvalid, 1);
    @(negedge clks.clk);
    m_rvalid = 1'b1; m_rdata = {$urandom, $urandom};
    #1 chk("mr_txvalid", tx_valid, 1);
    #2 clks.rst = 1'b0;
    #1 chk("mr_busy_async", busy, 0);
    chk("mr_txvalid_async", tx_valid, 0);
    start = 1'b0; m_rvalid = 1'b0;
    @(negedge clks.clk) clks.rst = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clks.clk); #1;
      if (pop || desc_done || busy || timeout || err) cnt++;
    end
    chk("mr_quiet_after", cnt, 0);

`ifdef DMA_TX_TIMEOUT_EN
    do_reset(0);
    haddr = {1'b1, 15'd0, 16'd64, 32'hA000}; stack_empty = 1'b0; start = 1'b1; m_arready = 1'b0;
    k = 0; cnt = 0;
    while (!timeout && k < 200) begin
      @(negedge clks.clk); #1;
      if (m_arvalid) cnt++;
      k++;
    end
    start = 1'b0;
    chk("to_seen", timeout, 1);
    chk("to_addr_cycles", cnt, TO);
    chk("to_busy", busy, 0);
    chk("to_err", err, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
